// File: rtl/bitserial_subtractor.sv
// ---------------------------------------------------------------------------
// bitserial_subtractor
//
// Purpose:
//   Computes diff = a - b - bin on WIDTH-bit unsigned operands, one bit per
//   clock, LSB first, by reusing a single full-subtractor cell.
//   Operands enter through a valid/ready input port and the result leaves
//   through a valid/ready output port.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand word valid
//   in_ready   out  1      block can accept an operand word (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      final borrow out (a < b + bin, unsigned)
//   ovf        out  1      signed overflow of a - b, valid with out_valid
//                          (present only when BITSERIAL_SUB_OVF_EN is defined)
//
// Configuration macro:
//   BITSERIAL_SUB_OVF_EN - adds the ovf output and its flop.
//
// Handshake: a word transfers on a rising edge where valid and ready are both
//   high. valid, once raised, holds with its payload stable until that edge.
//   in_valid while in_ready is low is ignored and not buffered.
//
// Timing: the accept edge moves IDLE->RUN; RUN lasts WIDTH cycles (one bit
//   each); DONE follows, so out_valid is high in the (WIDTH+1)-th cycle after
//   the accept cycle. With out_ready held high an operation repeats every
//   WIDTH+2 cycles (no accept while in DONE).
// ---------------------------------------------------------------------------
module bitserial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BITSERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // The one full-subtractor cell, always looking at the current LSBs.
    logic bit_diff;
    logic bit_borrow;

    assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

`ifdef BITSERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef BITSERIAL_SUB_OVF_EN
        ovf_d     = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // Result bits enter at the MSB so that after WIDTH shifts the
                // first computed bit lands at bit 0.
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                br_d   = bit_borrow;
                if (cnt_q == LAST_BIT) begin
`ifdef BITSERIAL_SUB_OVF_EN
                    // At the MSB step a_q[0]/b_q[0] are the operand MSBs and
                    // bit_diff is the result MSB; the borrow in plays no part.
                    ovf_d = (a_q[0] != b_q[0]) && (bit_diff != a_q[0]);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BITSERIAL_SUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // After the last bit the borrow register holds the final borrow out and
    // nothing updates it again until the next accept.
    assign diff = diff_q;
    assign bout = br_q;

endmodule

// File: tb/tb_bitserial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_bitserial_subtractor
//
// Bench for bitserial_subtractor (WIDTH = 8). A table of operand records
// with expected results is applied one operation at a time; expected results
// are queued on accept and compared by a monitor on each output handshake.
// Hand-written sequences cover backpressure in DONE, reset in the middle of
// RUN, and back-to-back throughput.
// ---------------------------------------------------------------------------
module tb_bitserial_subtractor;

    localparam int W = 8;
    localparam int NV = 12;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef BITSERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bitserial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef BITSERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- vectors / model ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vbin, input logic [W-1:0] vd,
                                input logic vbo, input logic vov);
        vec_t v;
        v.a = va; v.b = vb; v.bin = vbin; v.d = vd; v.bo = vbo; v.ov = vov;
        return v;
    endfunction

    // Reference: plain (W+1)-bit arithmetic; the top bit is the borrow.
    function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vbin);
        vec_t v;
        logic [W:0] full;
        full  = {1'b0, va} - {1'b0, vb} - {{W{1'b0}}, vbin};
        v.a   = va; v.b = vb; v.bin = vbin;
        v.d   = full[W-1:0];
        v.bo  = full[W];
        v.ov  = (va[W-1] != vb[W-1]) && (full[W-1] != va[W-1]);
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];   // {ovf, bout, diff}
    logic [W+1:0] mon_e;
    int checks = 0;
    int errors = 0;
    int last_accept_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake happens at the next rising edge; values are stable here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got diff %0h bout %0b, expected no result", diff, bout);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_diff", diff, mon_e[W-1:0]);
                check("result_bout", bout, mon_e[W]);
`ifdef BITSERIAL_SUB_OVF_EN
                check("result_ovf", ovf, mon_e[W+1]);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge with the DUT in IDLE.
    task automatic run_op(input vec_t v, input int hold);
        int lat;
        out_ready = (hold == 0);
        check("in_ready_idle", in_ready, 1);
        a        = v.a;
        b        = v.b;
        bin      = v.bin;
        in_valid = 1'b1;
        exp_q.push_back({v.ov, v.bo, v.d});
        @(posedge clk); #1;
        last_accept_cyc = cyc;
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W + 1);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_diff", diff, v.d);
            check("hold_bout", bout, v.bo);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_hs_out_valid", out_valid, 0);
        check("after_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        int first_acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        vecs[0] = mk(8'd5,  8'd3,  1'b0, 8'h02, 1'b0, 1'b0);
        vecs[1] = mk(8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0);
        vecs[2] = mk(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        vecs[3] = mk(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        vecs[4] = mk(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        vecs[5] = mk(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        for (int i = 6; i < NV; i++) begin
            vecs[i] = model(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
`ifdef BITSERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors; vector 1 also exercises 5 cycles of backpressure.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], (i == 1) ? 5 : 0);
        end

        // Reset while RUN is processing bit 3: operation is discarded.
        out_ready = 1'b1;
        a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_diff", diff, 0);
        check("midrun_rst_bout", bout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrun_rst_no_output", out_valid, 0);
        run_op(mk(8'd10, 8'd1, 1'b0, 8'h09, 1'b0, 1'b0), 0);

        // Back-to-back throughput with out_ready held high.
        run_op(model(8'h3C, 8'h7A, 1'b1), 0);
        first_acc = last_accept_cyc;
        run_op(model(8'hC3, 8'h0F, 1'b0), 0);
        check("throughput_period", last_accept_cyc - first_acc, W + 2);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
